// File: rtl/id_ex_alu_issue_pkg.sv
// Shared ALU codes plus MIPS opcode/funct constants used by decode and the ALU.
// Also holds the immediate-extension helpers.
package id_ex_alu_issue_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLL = 3'd4,
    ALU_SRL = 3'd5,
    ALU_SLT = 3'd6
  } alu_ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] imm);
    return {16'h0000, imm};
  endfunction

endpackage

// File: rtl/id_ex_alu_issue_if.sv
// ID->EX issue channel: valid/ready instruction offer in, decoded ALU op out.
// slave is the issue block's view, master is the surrounding pipeline's view.
interface id_ex_alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_reg1;
  logic [31:0] out_reg2;
  logic [2:0]  out_alu_ctrl;
  logic [4:0]  out_shamt;
  logic        out_illegal;
  logic [15:0] issue_cnt;

  modport slave (
    input  in_valid, instr, rs_data, rt_data, flush, out_ready,
    output in_ready, out_valid, out_reg1, out_reg2, out_alu_ctrl, out_shamt,
           out_illegal, issue_cnt
  );

  modport master (
    output in_valid, instr, rs_data, rt_data, flush, out_ready,
    input  in_ready, out_valid, out_reg1, out_reg2, out_alu_ctrl, out_shamt,
           out_illegal, issue_cnt
  );
endinterface

// File: rtl/id_ex_alu_issue_alu_decode.sv
// Combinational MIPS decode to ALU operands/code; no latency, no flow control.
// Unsupported encodings yield code 0 with zero operands and illegal set.
module alu_decode
  import id_ex_alu_issue_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] reg1,
  output logic [31:0] reg2,
  output logic [2:0]  alu_ctrl,
  output logic [4:0]  shamt,
  output logic        illegal
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [15:0] imm;
  alu_ctrl_t ctrl;
  logic unused_reg_fields;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];
  // Register numbers were already used by the register file read.
  assign unused_reg_fields = ^instr[25:16];

  always_comb begin
    reg1    = '0;
    reg2    = '0;
    ctrl    = ALU_ADD;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        reg1 = rs_data;
        reg2 = rt_data;
        case (funct)
          FN_ADD, FN_ADDU: ctrl = ALU_ADD;
          FN_SUB, FN_SUBU: ctrl = ALU_SUB;
          FN_AND:          ctrl = ALU_AND;
          FN_OR:           ctrl = ALU_OR;
          FN_SLL:          ctrl = ALU_SLL;
          FN_SRL:          ctrl = ALU_SRL;
          FN_SLT:          ctrl = ALU_SLT;
          default: begin
            reg1    = '0;
            reg2    = '0;
            illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: begin
        reg1 = rs_data;
        reg2 = sext16(imm);
      end
      OP_SLTI: begin
        reg1 = rs_data;
        reg2 = sext16(imm);
        ctrl = ALU_SLT;
      end
      OP_ANDI: begin
        reg1 = rs_data;
        reg2 = zext16(imm);
        ctrl = ALU_AND;
      end
      OP_ORI: begin
        reg1 = rs_data;
        reg2 = zext16(imm);
        ctrl = ALU_OR;
      end
      OP_BEQ: begin
        reg1 = rs_data;
        reg2 = rt_data;
        ctrl = ALU_SUB;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign alu_ctrl = ctrl;
  assign shamt    = (ctrl == ALU_SLL || ctrl == ALU_SRL) ? instr[10:6] : 5'd0;

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID->EX issue register: decodes on accept, presents next cycle (1-cycle latency).
// Holds output while EX stalls, refills on consume with no bubble; flush drops everything.
module id_ex_alu_issue
  import id_ex_alu_issue_pkg::*;
(
  input  logic clk,
  input  logic reset,
  id_ex_alu_issue_if.slave bus
);

  logic [31:0] dec_reg1;
  logic [31:0] dec_reg2;
  logic [2:0]  dec_ctrl;
  logic [4:0]  dec_shamt;
  logic        dec_illegal;

  logic        valid_q,   valid_d;
  logic [31:0] reg1_q,    reg1_d;
  logic [31:0] reg2_q,    reg2_d;
  logic [2:0]  ctrl_q,    ctrl_d;
  logic [4:0]  shamt_q,   shamt_d;
  logic        illegal_q, illegal_d;
  logic [15:0] cnt_q,     cnt_d;

  logic in_ready;
  logic accept;
  logic consume;

  alu_decode u_decode (
    .instr    (bus.instr),
    .rs_data  (bus.rs_data),
    .rt_data  (bus.rt_data),
    .reg1     (dec_reg1),
    .reg2     (dec_reg2),
    .alu_ctrl (dec_ctrl),
    .shamt    (dec_shamt),
    .illegal  (dec_illegal)
  );

  assign in_ready = !bus.flush && (!valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  // A flushed operation is squashed, so it does not count as issued.
  assign consume  = valid_q && bus.out_ready && !bus.flush;

  always_comb begin
    valid_d   = valid_q;
    reg1_d    = reg1_q;
    reg2_d    = reg2_q;
    ctrl_d    = ctrl_q;
    shamt_d   = shamt_q;
    illegal_d = illegal_q;
    cnt_d     = consume ? cnt_q + 16'd1 : cnt_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d   = 1'b1;
      reg1_d    = dec_reg1;
      reg2_d    = dec_reg2;
      ctrl_d    = dec_ctrl;
      shamt_d   = dec_shamt;
      illegal_d = dec_illegal;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      reg1_q    <= '0;
      reg2_q    <= '0;
      ctrl_q    <= '0;
      shamt_q   <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      reg1_q    <= reg1_d;
      reg2_q    <= reg2_d;
      ctrl_q    <= ctrl_d;
      shamt_q   <= shamt_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = valid_q;
  assign bus.out_reg1     = reg1_q;
  assign bus.out_reg2     = reg2_q;
  assign bus.out_alu_ctrl = ctrl_q;
  assign bus.out_shamt    = shamt_q;
  assign bus.out_illegal  = illegal_q;
  assign bus.issue_cnt    = cnt_q;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Bench for id_ex_alu_issue: directed cases plus random traffic against a
// transaction-level reference of the issue slot and decode table.
module tb_id_ex_alu_issue;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  id_ex_alu_issue_if bus ();

  id_ex_alu_issue dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference: one slot that is either empty or holds a decoded op.
  logic        m_valid;
  logic [31:0] m_r1, m_r2;
  logic [2:0]  m_ctrl;
  logic [4:0]  m_sh;
  logic        m_ill;
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void ref_dec(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt,
                                  output logic [31:0] r1, output logic [31:0] r2,
                                  output logic [2:0] c, output logic [4:0] sh, output logic il);
    logic [31:0] se, ze;
    se = 32'($signed(i[15:0]));
    ze = 32'(i[15:0]);
    r1 = 0; r2 = 0; c = 0; il = 0;
    if (i[31:26] == 6'h00) begin
      case (i[5:0])
        6'h20, 6'h21: c = 0;
        6'h22, 6'h23: c = 1;
        6'h24: c = 2;
        6'h25: c = 3;
        6'h00: c = 4;
        6'h02: c = 5;
        6'h2A: c = 6;
        default: il = 1;
      endcase
      if (!il) begin r1 = rs; r2 = rt; end
    end else begin
      case (i[31:26])
        6'h08, 6'h23, 6'h2B: begin r1 = rs; r2 = se; c = 0; end
        6'h0A: begin r1 = rs; r2 = se; c = 6; end
        6'h0C: begin r1 = rs; r2 = ze; c = 2; end
        6'h0D: begin r1 = rs; r2 = ze; c = 3; end
        6'h04: begin r1 = rs; r2 = rt; c = 1; end
        default: il = 1;
      endcase
    end
    sh = (c == 4 || c == 5) ? i[10:6] : 5'd0;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [10];
    logic [5:0] fns [10];
    logic [31:0] r;
    ops = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h23, 6'h2B, 6'h0A, 6'h0C, 6'h0D, 6'h04};
    fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h00, 6'h02, 6'h2A, 6'h00};
    r = $urandom();
    if ($urandom_range(0, 9) == 0) return r;
    fns[9] = r[5:0];
    return {ops[$urandom_range(0, 9)], r[25:6], fns[$urandom_range(0, 9)]};
  endfunction

  task automatic model_reset();
    m_valid = 0; m_r1 = 0; m_r2 = 0; m_ctrl = 0; m_sh = 0; m_ill = 0; m_cnt = 0;
  endtask

  task automatic check_outputs();
    chk("out_valid", bus.out_valid, m_valid);
    chk("out_reg1", bus.out_reg1, m_r1);
    chk("out_reg2", bus.out_reg2, m_r2);
    chk("out_alu_ctrl", bus.out_alu_ctrl, m_ctrl);
    chk("out_shamt", bus.out_shamt, m_sh);
    chk("out_illegal", bus.out_illegal, m_ill);
    chk("issue_cnt", bus.issue_cnt, m_cnt);
  endtask

  // Drive one cycle of inputs, check in_ready, advance the model, check outputs.
  task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] rs,
                      input logic [31:0] rt, input logic fl, input logic ordy);
    logic rdy;
    @(negedge clk);
    bus.in_valid = iv; bus.instr = ins; bus.rs_data = rs; bus.rt_data = rt;
    bus.flush = fl; bus.out_ready = ordy;
    #1;
    rdy = !fl && (!m_valid || ordy);
    chk("in_ready", bus.in_ready, rdy);
    if (m_valid && ordy && !fl) m_cnt = m_cnt + 16'd1;
    if (fl) m_valid = 0;
    else if (iv && rdy) begin
      ref_dec(ins, rs, rt, m_r1, m_r2, m_ctrl, m_sh, m_ill);
      m_valid = 1;
    end else if (m_valid && ordy) m_valid = 0;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  logic [15:0] cnt_save;
  localparam logic [31:0] ADD_I = 32'h00221820;

  initial begin
    bus.in_valid = 0; bus.instr = 0; bus.rs_data = 0; bus.rt_data = 0;
    bus.flush = 0; bus.out_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    reset = 0;

    // add $3,$1,$2
    step(1, ADD_I, 32'd5, 32'd7, 0, 1);
    chk("add_ctrl", bus.out_alu_ctrl, 32'd0);
    chk("add_reg1", bus.out_reg1, 32'd5);
    chk("add_reg2", bus.out_reg2, 32'd7);
    step(0, 0, 0, 0, 0, 1);
    chk("add_cnt", bus.issue_cnt, 32'd1);

    // addi / ori with imm 0xFFFF
    step(1, {6'h08, 5'd1, 5'd2, 16'hFFFF}, 32'd10, 32'd3, 0, 1);
    chk("addi_reg2", bus.out_reg2, 32'hFFFF_FFFF);
    chk("addi_reg1", bus.out_reg1, 32'd10);
    step(1, {6'h0D, 5'd1, 5'd2, 16'hFFFF}, 32'd10, 32'd3, 0, 1);
    chk("ori_reg2", bus.out_reg2, 32'h0000_FFFF);
    chk("ori_ctrl", bus.out_alu_ctrl, 32'd3);

    // sll by 4 then EX stalls for three cycles
    step(1, {6'h00, 5'd0, 5'd1, 5'd3, 5'd4, 6'h00}, 32'd0, 32'h11, 0, 1);
    cnt_save = bus.issue_cnt;
    repeat (3) begin
      step(1, ADD_I, 32'd1, 32'd2, 0, 0);
      chk("sll_ctrl_hold", bus.out_alu_ctrl, 32'd4);
      chk("sll_shamt_hold", bus.out_shamt, 32'd4);
      chk("stall_in_ready", bus.in_ready, 32'd0);
    end
    chk("stall_cnt", bus.issue_cnt, cnt_save);
    step(0, 0, 0, 0, 0, 1);
    chk("unstall_cnt", bus.issue_cnt, cnt_save + 16'd1);

    // back-to-back stream, then flush mid-stream
    for (int k = 0; k < 6; k++) begin
      step(1, rand_instr(), $urandom(), $urandom(), 0, 1);
      chk("stream_valid", bus.out_valid, 32'd1);
    end
    step(1, ADD_I, 32'd9, 32'd9, 1, 1);
    chk("flush_valid", bus.out_valid, 32'd0);

    // unsupported opcode
    step(1, {6'h3F, 26'h155_5555}, 32'hDEAD, 32'hBEEF, 0, 1);
    chk("ill_flag", bus.out_illegal, 32'd1);
    chk("ill_ctrl", bus.out_alu_ctrl, 32'd0);
    chk("ill_reg1", bus.out_reg1, 32'd0);
    chk("ill_reg2", bus.out_reg2, 32'd0);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      step(logic'($urandom_range(0, 3) != 0), rand_instr(), $urandom(), $urandom(),
           logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 2) != 0));
    end

    // reset while EX is stalled on a held op
    step(1, ADD_I, 32'd4, 32'd6, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2 reset = 1;
    #1;
    model_reset();
    check_outputs();
    chk("rst_in_ready", bus.in_ready, 32'd1);
    @(negedge clk);
    reset = 0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 32'd1);
    step(1, ADD_I, 32'd5, 32'd7, 0, 0);

    // 65535 consumes from zero, then one more wraps the counter
    @(negedge clk);
    bus.in_valid = 1; bus.instr = ADD_I; bus.rs_data = 32'd5; bus.rt_data = 32'd7;
    bus.flush = 0; bus.out_ready = 1;
    repeat (65535) @(posedge clk);
    #1;
    m_cnt = m_cnt + 16'd65535;
    check_outputs();
    chk("cnt_full", bus.issue_cnt, 32'h0000_FFFF);
    step(0, 0, 0, 0, 0, 1);
    chk("cnt_wrap", bus.issue_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_alu_issue.md
ID_EX_ALU_ISSUE -- requirements
Module: id_ex_alu_issue

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  ID stage offers an instruction.
REQ-005 in_ready  output  1  block accepts the offered instruction this cycle.
REQ-006 instr  input  32  MIPS instruction word.
REQ-007 rs_data  input  32  register-file value of rs.
REQ-008 rt_data  input  32  register-file value of rt.
REQ-009 flush  input  1  discard held and offered instructions (branch taken).
REQ-010 out_valid  output  1  an ALU operation is presented to EX.
REQ-011 out_ready  input  1  EX consumes the presented operation.
REQ-012 out_reg1  output  32  ALU operand reg1.
REQ-013 out_reg2  output  32  ALU operand reg2.
REQ-014 out_alu_ctrl  output  3  ALU code: 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 srl, 6 slt.
REQ-015 out_shamt  output  5  shift amount (instr[10:6]).
REQ-016 out_illegal  output  1  presented instruction has an unsupported opcode or funct.
REQ-017 issue_cnt  output  16  count of operations consumed by EX.

Function
REQ-018 Decode SHALL be: opcode 0 with funct 0x20/0x21 -> 0, 0x22/0x23 -> 1, 0x24 -> 2, 0x25 -> 3, 0x00 -> 4, 0x02 -> 5, 0x2A -> 6; R-type reg1=rs_data, reg2=rt_data.
REQ-019 I-type SHALL use reg1=rs_data and reg2=imm: addi 0x08, lw 0x23, sw 0x2B -> 0 with sign-extended imm; slti 0x0A -> 6 with sign-extended imm; andi 0x0C -> 2 and ori 0x0D -> 3 with zero-extended imm.
REQ-020 beq 0x04 SHALL decode to code 1 with reg1=rs_data, reg2=rt_data.
REQ-021 Any other opcode/funct SHALL decode to code 0, reg1=reg2=0, shamt 0, illegal=1; otherwise illegal=0.
REQ-022 out_shamt SHALL equal instr[10:6] for codes 4/5 and 0 for all other codes.
REQ-023 in_ready SHALL be combinational: !out_valid || out_ready, and 0 whenever flush=1.
REQ-024 Accept occurs when in_valid && in_ready; decoded fields SHALL be registered and out_valid=1 on the next edge (latency 1 cycle).
REQ-025 While out_valid && !out_ready, all out_* fields SHALL hold unchanged.
REQ-026 Simultaneous consume and accept SHALL replace the entry with no bubble (full throughput).
REQ-027 Consume without accept SHALL clear out_valid on the next edge.
REQ-028 flush=1 SHALL clear out_valid on the next edge regardless of out_ready or in_valid; nothing is captured that cycle.
REQ-029 issue_cnt SHALL increment by 1 on each edge where out_valid && out_ready && !flush, wrapping 0xFFFF -> 0x0000.
REQ-030 Illegal instructions SHALL flow through the handshake like legal ones.

Reset
REQ-031 reset SHALL asynchronously force out_valid=0, out_reg1=0, out_reg2=0, out_alu_ctrl=0, out_shamt=0, out_illegal=0, issue_cnt=0.
REQ-032 Reset asserted mid-transfer SHALL drop the held operation; the first accept after release SHALL behave as from idle.

Structure
REQ-033 A shared package SHALL hold ALU code constants (0-6), opcode constants and funct constants, shared with the ALU.
REQ-034 Decode SHALL be a combinational sub-module alu_decode (instr, rs_data, rt_data -> reg1, reg2, alu_ctrl, shamt, illegal); handshake register and counter stay in id_ex_alu_issue.

Verification
REQ-035 add $3,$1,$2 (0x00221820), rs=5, rt=7, out_ready=1 -> next cycle out_valid=1, ctrl=0, reg1=5, reg2=7, illegal=0, issue_cnt increments.
REQ-036 addi imm 0xFFFF, rs=10 -> reg2=0xFFFFFFFF, ctrl=0; ori imm 0xFFFF -> reg2=0x0000FFFF, ctrl=3.
REQ-037 sll shamt 4 then out_ready=0 for 3 cycles -> ctrl=4, shamt=4 held, in_ready=0, issue_cnt unchanged until out_ready=1.
REQ-038 Back-to-back valid instructions with out_ready=1 -> one output per cycle, no bubble; flush during stream -> out_valid=0 next cycle, offered instruction dropped.
REQ-039 opcode 0x3F -> illegal=1, ctrl=0, operands 0; issue_cnt preset to 0xFFFF by 65535 consumes wraps to 0 on next consume.
REQ-040 Assert reset while out_valid=1, out_ready=0 -> all outputs 0 immediately, in_ready=1 after release.
